// File: rtl/sram_1rw_port_ctrl_if.sv
// Request/response bundle between core logic and the 1RW SRAM port controller.
interface sram_1rw_port_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 4
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/sram_1rw_port_ctrl.sv
// Single-port OpenRAM 1RW initiator: one operation in flight, registered macro pins,
// read data returned on a valid/ready channel, saturating debug counters.
module sram_1rw_port_ctrl #(
    parameter int unsigned DATA_WIDTH = 2,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned READ_LAT   = 1,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                  clk0,
    input  logic                  rst0,
    sram_1rw_port_ctrl_if.slave   bus,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  rd_cnt,
    output logic [CNT_WIDTH-1:0]  wr_cnt
);

    localparam int unsigned LatW = $clog2(READ_LAT + 1);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

    state_e                state_q, state_d;
    logic                  csb_q, csb_d;
    logic                  web_q, web_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] din_q, din_d;
    logic [LatW-1:0]       lat_q, lat_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [CNT_WIDTH-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_WIDTH-1:0]  wr_cnt_q, wr_cnt_d;

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        web_d       = web_q;
        addr_d      = addr_q;
        din_d       = din_q;
        lat_d       = lat_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;

        case (state_q)
            StIdle: begin
                if (bus.req_valid) begin
                    csb_d   = 1'b0;
                    web_d   = ~bus.req_we;
                    addr_d  = bus.req_addr;
                    din_d   = bus.req_wdata;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                // The macro captures the command on this edge; release the pins at once.
                csb_d = 1'b1;
                web_d = 1'b1;
                if (!web_q) begin
                    if (wr_cnt_q != '1) wr_cnt_d = wr_cnt_q + CNT_WIDTH'(1);
                    state_d = StIdle;
                end else begin
                    lat_d   = LatW'(READ_LAT);
                    state_d = StWait;
                end
            end
            StWait: begin
                if (lat_q == LatW'(1)) begin
                    rsp_rdata_d = dout0;
                    rsp_valid_d = 1'b1;
                    state_d     = StResp;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StResp: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (rd_cnt_q != '1) rd_cnt_d = rd_cnt_q + CNT_WIDTH'(1);
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q     <= StIdle;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            addr_q      <= '0;
            din_q       <= '0;
            lat_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            lat_q       <= lat_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
        end
    end

    assign bus.req_ready = (state_q == StIdle);
    assign busy          = (state_q != StIdle);
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign csb0          = csb_q;
    assign web0          = web_q;
    assign addr0         = addr_q;
    assign din0          = din_q;
    assign rd_cnt        = rd_cnt_q;
    assign wr_cnt        = wr_cnt_q;

endmodule

// File: tb/tb_sram_1rw_port_ctrl.sv
// Directed bench: three controller instances (default, 2-bit counters, READ_LAT=3), each with
// a behavioural 1RW macro; read data checked against a scoreboard queue.
module tb_sram_1rw_port_ctrl;

    logic       clk0 = 1'b0;
    logic       rst0;
    logic       req_valid;
    logic       req_we;
    logic [3:0] req_addr;
    logic [1:0] req_wdata;
    logic       rsp_ready;
    logic [1:0] tgt;

    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned rsp_seen = 0;
    int unsigned cyc = 0;
    bit          mon_on = 1'b0;
    bit [2:0]    prev_low = '0;

    logic [1:0] exp_q [$];
    logic [1:0] ref_mem [3][16];
    logic [1:0] mem [3][16];

    logic [2:0] csb, web, busy;
    logic [3:0] addr [3];
    logic [1:0] din [3];
    logic [1:0] dout [3];
    logic [15:0] rd_cnt0, wr_cnt0, rd_cnt2, wr_cnt2;
    logic [1:0]  rd_cnt1, wr_cnt1;

    always #5 clk0 = ~clk0;
    always @(posedge clk0) cyc++;

    sram_1rw_port_ctrl_if #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) bus0 ();
    sram_1rw_port_ctrl_if #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) bus1 ();
    sram_1rw_port_ctrl_if #(.DATA_WIDTH(2), .ADDR_WIDTH(4)) bus2 ();

    assign bus0.req_valid = req_valid && (tgt == 2'd0);
    assign bus1.req_valid = req_valid && (tgt == 2'd1);
    assign bus2.req_valid = req_valid && (tgt == 2'd2);
    assign bus0.req_we = req_we;      assign bus1.req_we = req_we;      assign bus2.req_we = req_we;
    assign bus0.req_addr = req_addr;  assign bus1.req_addr = req_addr;  assign bus2.req_addr = req_addr;
    assign bus0.req_wdata = req_wdata; assign bus1.req_wdata = req_wdata;
    assign bus2.req_wdata = req_wdata;
    assign bus0.rsp_ready = rsp_ready; assign bus1.rsp_ready = rsp_ready;
    assign bus2.rsp_ready = rsp_ready;

    logic [2:0] rdy_v, rv_v;
    logic [1:0] rd_v [3];
    assign rdy_v = {bus2.req_ready, bus1.req_ready, bus0.req_ready};
    assign rv_v  = {bus2.rsp_valid, bus1.rsp_valid, bus0.rsp_valid};
    assign rd_v[0] = bus0.rsp_rdata;
    assign rd_v[1] = bus1.rsp_rdata;
    assign rd_v[2] = bus2.rsp_rdata;

    sram_1rw_port_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .READ_LAT(1), .CNT_WIDTH(16)) dut0 (
        .clk0(clk0), .rst0(rst0), .bus(bus0), .csb0(csb[0]), .web0(web[0]), .addr0(addr[0]),
        .din0(din[0]), .dout0(dout[0]), .busy(busy[0]), .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0));
    sram_1rw_port_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .READ_LAT(1), .CNT_WIDTH(2)) dut1 (
        .clk0(clk0), .rst0(rst0), .bus(bus1), .csb0(csb[1]), .web0(web[1]), .addr0(addr[1]),
        .din0(din[1]), .dout0(dout[1]), .busy(busy[1]), .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1));
    sram_1rw_port_ctrl #(.DATA_WIDTH(2), .ADDR_WIDTH(4), .READ_LAT(3), .CNT_WIDTH(16)) dut2 (
        .clk0(clk0), .rst0(rst0), .bus(bus2), .csb0(csb[2]), .web0(web[2]), .addr0(addr[2]),
        .din0(din[2]), .dout0(dout[2]), .busy(busy[2]), .rd_cnt(rd_cnt2), .wr_cnt(wr_cnt2));

    // Behavioural macro: command captured on the edge where csb0 is low.
    always @(posedge clk0) begin
        for (int k = 0; k < 3; k++) begin
            if (!csb[k]) begin
                if (!web[k]) mem[k][addr[k]] <= din[k];
                else         dout[k] <= mem[k][addr[k]];
            end
        end
    end

    function automatic void chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endfunction

    always @(negedge clk0) begin
        if (mon_on) begin
            if (rv_v[tgt] && rsp_ready) begin
                chk("rsp_expected", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    chk("rsp_rdata", 32'(rd_v[tgt]), 32'(exp_q.pop_front()));
                    rsp_seen++;
                end
            end
            for (int k = 0; k < 3; k++) begin
                chk("csb_back_to_back", 32'(prev_low[k] && !csb[k]), 32'd0);
                chk("web_without_csb", 32'(!web[k] && csb[k]), 32'd0);
                prev_low[k] = !csb[k];
            end
        end
    end

    task automatic step();
        @(posedge clk0);
        #1;
    endtask

    task automatic send(input logic we, input logic [3:0] a, input logic [1:0] d);
        int n = 0;
        req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = d;
        while (!rdy_v[tgt] && n < 100) begin step(); n++; end
        chk("req_ready_wait", 32'(rdy_v[tgt]), 32'd1);
        if (we) ref_mem[tgt][a] = d;
        else    exp_q.push_back(ref_mem[tgt][a]);
        step();
        req_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (!rv_v[tgt] && n < 20) begin step(); n++; end
        chk("rsp_valid_timeout", 32'(rv_v[tgt]), 32'd1);
    endtask

    initial begin
        int n;
        int unsigned c0;
        rst0 = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b1; tgt = 2'd0;
        step(); step();
        chk("rst_csb0", 32'(csb), 32'h7);
        chk("rst_web0", 32'(web), 32'h7);
        chk("rst_rsp_valid", 32'(rv_v), 32'h0);
        chk("rst_req_ready", 32'(rdy_v), 32'h7);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_cnts", 32'({rd_cnt0, wr_cnt0}), 32'h0);
        chk("rst_cnts_sat", 32'({rd_cnt1, wr_cnt1}), 32'h0);
        chk("rst_cnts_lat3", 32'({rd_cnt2, wr_cnt2}), 32'h0);
        rst0 = 1'b0;
        mon_on = 1'b1;

        // Reset while a read sits in WAIT: the read is abandoned.
        send(1'b0, 4'h0, 2'b00);
        chk("issue_busy", 32'(busy[0]), 32'd1);
        step();
        rst0 = 1'b1;
        step();
        rst0 = 1'b0;
        void'(exp_q.pop_back());
        chk("abort_rsp_valid", 32'(bus0.rsp_valid), 32'd0);
        chk("abort_rd_cnt", 32'(rd_cnt0), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk("abort_no_rsp", 32'(bus0.rsp_valid), 32'd0);
            step();
        end

        // Write then read back, checking pin timing and latency.
        send(1'b1, 4'h3, 2'b10);
        chk("wr_csb0_low", 32'({csb[0], web[0]}), 32'h0);
        chk("wr_addr_din", 32'({addr[0], din[0]}), 32'({4'h3, 2'b10}));
        step();
        chk("wr_csb0_release", 32'({csb[0], web[0]}), 32'h3);
        chk("wr_cnt_1", 32'(wr_cnt0), 32'd1);
        send(1'b0, 4'h3, 2'b00);
        chk("rd_csb0_low", 32'({csb[0], web[0]}), 32'h1);
        wait_rsp(n);
        chk("rd_latency", 32'(n), 32'd2);
        chk("rd_data", 32'(bus0.rsp_rdata), 32'(2'b10));
        step();
        chk("rd_cnt_1", 32'(rd_cnt0), 32'd1);
        chk("rd_idle", 32'(busy[0]), 32'd0);

        // Fill all addresses, then read them back.
        c0 = cyc;
        for (int i = 0; i < 16; i++) send(1'b1, 4'(i), 2'(i));
        chk("write_throughput", 32'(cyc - c0), 32'd31);
        for (int i = 0; i < 16; i++) send(1'b0, 4'(i), 2'b00);
        n = 0;
        while ((exp_q.size() != 0 || busy[0]) && n < 200) begin step(); n++; end
        chk("drain_fill", 32'(exp_q.size()), 32'd0);
        chk("wr_cnt_fill", 32'(wr_cnt0), 32'd17);
        chk("rd_cnt_fill", 32'(rd_cnt0), 32'd17);

        // Response backpressure; a request offered meanwhile must be ignored.
        rsp_ready = 1'b0;
        send(1'b0, 4'h5, 2'b00);
        wait_rsp(n);
        req_valid = 1'b1; req_we = 1'b1; req_addr = 4'h5; req_wdata = 2'b11;
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp_valid", 32'(bus0.rsp_valid), 32'd1);
            chk("hold_rsp_rdata", 32'(bus0.rsp_rdata), 32'(2'b01));
            chk("hold_req_ready", 32'(bus0.req_ready), 32'd0);
            chk("hold_csb0", 32'(csb[0]), 32'd1);
            step();
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        step();
        chk("hs_idle", 32'({busy[0], bus0.req_ready, bus0.rsp_valid}), 32'(3'b010));
        chk("hs_rd_cnt", 32'(rd_cnt0), 32'd18);
        chk("hs_wr_cnt", 32'(wr_cnt0), 32'd17);

        // Two-bit counters saturate at 3.
        tgt = 2'd1;
        for (int i = 1; i <= 5; i++) begin
            send(1'b1, 4'(i), 2'(i));
            step();
            chk("sat_wr_cnt", 32'(wr_cnt1), (i > 3) ? 32'd3 : 32'(i));
        end

        // READ_LAT=3 instance: accept-to-valid of 4 cycles.
        tgt = 2'd2;
        send(1'b1, 4'h9, 2'b11);
        step();
        send(1'b0, 4'h9, 2'b00);
        wait_rsp(n);
        chk("lat3_latency", 32'(n), 32'd4);
        chk("lat3_data", 32'(bus2.rsp_rdata), 32'(2'b11));
        step();
        chk("lat3_cnts", 32'({rd_cnt2, wr_cnt2}), 32'h0001_0001);

        step();
        chk("rsp_count", 32'(rsp_seen), 32'd19);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
